// File: rtl/prt_dp_pkg.sv
// Shared DisplayPort TX symbol constants and the x^16+x^5+x^4+x^3+1 scrambler LFSR helpers.
package prt_dp_pkg;

  typedef struct packed {
    logic       k;
    logic [7:0] dat;
  } sym_t;

  localparam logic [7:0]  P_SYM_BS    = 8'hBC;  // K28.5
  localparam logic [7:0]  P_SYM_SR    = 8'h1C;  // K28.0
  localparam logic [15:0] P_SCRM_SEED = 16'hFFFF;

  // Advance the Galois LFSR by one symbol slot (8 bit times).
  function automatic logic [15:0] scrm_adv8(input logic [15:0] lfsr);
    logic [15:0] l;
    l = lfsr;
    for (int i = 0; i < 8; i++) begin
      l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
    end
    return l;
  endfunction

  // Scrambling byte for the current slot: data bit j uses LFSR bit 15-j.
  function automatic logic [7:0] scrm_byte(input logic [15:0] lfsr);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < 8; j++) begin
      b[j] = lfsr[15-j];
    end
    return b;
  endfunction

endpackage

// File: rtl/prt_dp_tx_lnk_if.sv
// DisplayPort TX link bundle: per lane, per sublane a k flag, 8-bit data and disparity controls.
interface prt_dp_tx_lnk_if #(
  parameter int P_LANES = 4,
  parameter int P_SPL   = 2
);
  logic [P_LANES-1:0][P_SPL-1:0]      k;
  logic [P_LANES-1:0][P_SPL-1:0][7:0] dat;
  logic [P_LANES-1:0][P_SPL-1:0]      disp_ctl;
  logic [P_LANES-1:0][P_SPL-1:0]      disp_val;

  modport snk (input k, dat);
  modport src (output k, dat, disp_ctl, disp_val);
endinterface

// File: rtl/prt_dptx_scrm_lane.sv
// One lane of the DP TX scrambler: P_SPL-slot LFSR chain, BS->SR substitution and output register.
module prt_dptx_scrm_lane
  import prt_dp_pkg::*;
#(
  parameter int P_SPL = 2
)(
  input  logic                  CLK_IN,
  input  logic                  RST_IN,
  input  logic                  en,
  input  logic                  act,
  input  logic                  sub,
  input  logic [P_SPL-1:0]      k,
  input  logic [P_SPL-1:0][7:0] dat,
  output logic [P_SPL-1:0]      k_p1,
  output logic [P_SPL-1:0][7:0] dat_p1
);

  logic [15:0]           lfsr_p1;
  logic [15:0]           lfsr_p0;
  logic [P_SPL-1:0]      k_p0;
  logic [P_SPL-1:0][7:0] dat_p0;

  // Stage p0: walk the slots in order; an SR reseeds the chain for the following slot.
  always_comb begin
    logic [15:0] st;
    st     = lfsr_p1;
    k_p0   = k;
    dat_p0 = dat;
    for (int s = 0; s < P_SPL; s++) begin
      if (sub && k[s] && (dat[s] == P_SYM_BS)) begin
        dat_p0[s] = P_SYM_SR;
        st        = P_SCRM_SEED;
      end else begin
        if (!k[s]) begin
          dat_p0[s] = dat[s] ^ scrm_byte(st);
        end
        st = scrm_adv8(st);
      end
    end
    lfsr_p0 = st;
  end

  // Stage p1: output register; idle lanes are zeroed and parked at the seed.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN || !act) begin
      k_p1    <= '0;
      dat_p1  <= '0;
      lfsr_p1 <= P_SCRM_SEED;
    end else if (!en) begin
      k_p1    <= k;
      dat_p1  <= dat;
      lfsr_p1 <= P_SCRM_SEED;
    end else begin
      k_p1    <= k_p0;
      dat_p1  <= dat_p0;
      lfsr_p1 <= lfsr_p0;
    end
  end

endmodule

// File: rtl/prt_dptx_scrm_ml.sv
// DP TX multi-lane scrambler with periodic / forced SR insertion.
// Optional SR statistics counter enabled by defining PRT_DPTX_SCRM_STAT_EN.
module prt_dptx_scrm_ml
  import prt_dp_pkg::*;
#(
  parameter int P_SIM       = 0,
  parameter int P_LANES     = 4,
  parameter int P_SPL       = 2,
  parameter int P_BS_PER_SR = 512
)(
  input  logic         CLK_IN,
  input  logic         RST_IN,
  input  logic         CTL_EN_IN,
  input  logic         CTL_EFM_IN,
  input  logic [1:0]   CTL_LANES_IN,
  input  logic         CTL_SR_REQ_IN,
  output logic         CTL_SR_ACK_OUT,
  prt_dp_tx_lnk_if.snk LNK_SNK_IF,
  prt_dp_tx_lnk_if.src LNK_SRC_IF
`ifdef PRT_DPTX_SCRM_STAT_EN
  ,
  output logic [15:0]  STA_SR_CNT_OUT
`endif
);

  // Counter runs 0..period-1; the BS seen at count 0 is the one turned into SR.
  localparam logic [15:0] P_CNT_MAX = (P_SIM != 0) ? 16'd9 : 16'(P_BS_PER_SR - 1);

  logic [P_LANES-1:0][P_SPL-1:0]      k_i, k_o;
  logic [P_LANES-1:0][P_SPL-1:0][7:0] dat_i, dat_o;
  logic [P_LANES-1:0]                 act;
  logic                               efm_q;
  logic [1:0]                         lanes_q;
  logic [15:0]                        cnt_q;
  logic                               pend_q;
  logic                               bs_det;
  logic                               sub;

  assign k_i   = LNK_SNK_IF.k;
  assign dat_i = LNK_SNK_IF.dat;

  assign bs_det = CTL_EN_IN &&
                  (efm_q ? (k_i[0][P_SPL-1] && (dat_i[0][P_SPL-1] == P_SYM_BS))
                         : (k_i[0][0]       && (dat_i[0][0]       == P_SYM_BS)));
  assign sub    = bs_det && ((cnt_q == 16'd0) || pend_q);

  // Lane config is applied from a registered copy, so changes land one cycle later.
  always_ff @(posedge CLK_IN) begin
    efm_q   <= CTL_EFM_IN;
    lanes_q <= CTL_LANES_IN;
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      cnt_q          <= '0;
      pend_q         <= 1'b0;
      CTL_SR_ACK_OUT <= 1'b0;
    end else begin
      CTL_SR_ACK_OUT <= bs_det && pend_q;
      if (!CTL_EN_IN) begin
        cnt_q  <= '0;
        pend_q <= 1'b0;
      end else begin
        if (bs_det) begin
          if (pend_q) begin
            cnt_q <= 16'd1;
          end else if (cnt_q == P_CNT_MAX) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        pend_q <= CTL_SR_REQ_IN || (pend_q && !sub);
      end
    end
  end

`ifdef PRT_DPTX_SCRM_STAT_EN
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      STA_SR_CNT_OUT <= '0;
    end else if (sub && (STA_SR_CNT_OUT != 16'hFFFF)) begin
      STA_SR_CNT_OUT <= STA_SR_CNT_OUT + 16'd1;
    end
  end
`endif

  // Lane code 3 is reserved and behaves like 4 lanes.
  for (genvar l = 0; l < P_LANES; l++) begin : g_lane
    assign act[l] = (l == 0) || ((l == 1) && (lanes_q != 2'd0)) || ((l >= 2) && lanes_q[1]);

    prt_dptx_scrm_lane #(
      .P_SPL (P_SPL)
    ) u_lane (
      .CLK_IN (CLK_IN),
      .RST_IN (RST_IN),
      .en     (CTL_EN_IN),
      .act    (act[l]),
      .sub    (sub),
      .k      (k_i[l]),
      .dat    (dat_i[l]),
      .k_p1   (k_o[l]),
      .dat_p1 (dat_o[l])
    );
  end

  assign LNK_SRC_IF.k        = k_o;
  assign LNK_SRC_IF.dat      = dat_o;
  assign LNK_SRC_IF.disp_ctl = '0;
  assign LNK_SRC_IF.disp_val = '0;

endmodule

// File: tb/tb_prt_dptx_scrm_ml.sv
// Scoreboard bench for prt_dptx_scrm_ml (P_SIM=1, 4 lanes x 2 symbols per lane).
module tb_prt_dptx_scrm_ml;

  localparam logic [8:0] BS9 = 9'h1BC;
  localparam logic [8:0] SR9 = 9'h11C;
  localparam logic [8:0] FL9 = 9'h17C;
  localparam logic [8:0] D00 = 9'h000;
  localparam logic [8:0] DFF = 9'h0FF;
  localparam logic [8:0] D17 = 9'h017;
  localparam logic [8:0] DC0 = 9'h0C0;
  localparam logic [8:0] DA5 = 9'h0A5;
  localparam logic [8:0] Z9  = 9'h000;

  logic       clk;
  logic       rst, en, efm, req, ack;
  logic [1:0] lanes;
  logic       c_rst, c_en, c_efm;
  logic [1:0] c_lanes;
`ifdef PRT_DPTX_SCRM_STAT_EN
  logic [15:0] sta;
`endif

  prt_dp_tx_lnk_if #(.P_LANES(4), .P_SPL(2)) snk_if ();
  prt_dp_tx_lnk_if #(.P_LANES(4), .P_SPL(2)) src_if ();

  prt_dptx_scrm_ml #(
    .P_SIM       (1),
    .P_LANES     (4),
    .P_SPL       (2),
    .P_BS_PER_SR (512)
  ) dut (
    .CLK_IN         (clk),
    .RST_IN         (rst),
    .CTL_EN_IN      (en),
    .CTL_EFM_IN     (efm),
    .CTL_LANES_IN   (lanes),
    .CTL_SR_REQ_IN  (req),
    .CTL_SR_ACK_OUT (ack),
    .LNK_SNK_IF     (snk_if),
    .LNK_SRC_IF     (src_if)
`ifdef PRT_DPTX_SCRM_STAT_EN
    ,
    .STA_SR_CNT_OUT (sta)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [71:0] q_sym[$];
  logic        q_ack[$];
  int          q_sta[$];
  string       q_nm[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          done    = 1'b0;

  // One stimulus cycle: all lanes get {i0,i1}; the expected output is queued.
  task automatic cyc(input logic [8:0] i0, input logic [8:0] i1,
                     input logic [8:0] e0, input logic [8:0] e1,
                     input logic eack, input logic r, input int nact,
                     input int esta, input string nm);
    logic [3:0][1:0][8:0] e;
    @(negedge clk);
    rst   = c_rst;
    en    = c_en;
    efm   = c_efm;
    lanes = c_lanes;
    req   = r;
    for (int l = 0; l < 4; l++) begin
      snk_if.k[l][0]   = i0[8];
      snk_if.dat[l][0] = i0[7:0];
      snk_if.k[l][1]   = i1[8];
      snk_if.dat[l][1] = i1[7:0];
      if (l < nact) begin
        e[l][0] = e0;
        e[l][1] = e1;
      end else begin
        e[l] = '0;
      end
    end
    q_sym.push_back(e);
    q_ack.push_back(eack);
    q_sta.push_back(esta);
    q_nm.push_back(nm);
  endtask

  logic [3:0][1:0][8:0] got;
  logic [71:0]          exp_sym;
  logic                 exp_ack;
  int                   exp_sta;
  string                exp_nm;
  logic [15:0]          got_sta;
  bit                   bad;

  always @(posedge clk) begin
    #1;
    if (q_sym.size() > 0) begin
      exp_sym = q_sym.pop_front();
      exp_ack = q_ack.pop_front();
      exp_sta = q_sta.pop_front();
      exp_nm  = q_nm.pop_front();
      for (int l = 0; l < 4; l++) begin
        for (int s = 0; s < 2; s++) begin
          got[l][s] = {src_if.k[l][s], src_if.dat[l][s]};
        end
      end
      bad = (got !== exp_sym) || (ack !== exp_ack) ||
            (src_if.disp_ctl !== 8'h00) || (src_if.disp_val !== 8'h00);
`ifdef PRT_DPTX_SCRM_STAT_EN
      got_sta = sta;
      if ((exp_sta >= 0) && (got_sta !== 16'(exp_sta))) bad = 1'b1;
`else
      got_sta = 16'd0;
`endif
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s: got sym=%h ack=%b sta=%0d, expected sym=%h ack=%b sta=%0d",
                 exp_nm, got, ack, got_sta, exp_sym, exp_ack, exp_sta);
      end
    end
    if (done) begin
      n_tests++;
      if (q_sym.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d entries left, expected 0", q_sym.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; efm = 1'b0; lanes = 2'd2; req = 1'b0;
    c_rst = 1'b1; c_en = 1'b0; c_efm = 1'b0; c_lanes = 2'd2;
    snk_if.k = '0; snk_if.dat = '0; snk_if.disp_ctl = '0; snk_if.disp_val = '0;
    repeat (2) @(negedge clk);

    cyc(DA5, DA5, Z9, Z9, 1'b0, 1'b0, 0, 0, "reset_data");
    cyc(BS9, FL9, Z9, Z9, 1'b0, 1'b0, 0, 0, "reset_bs");
    c_rst = 1'b0; c_en = 1'b1;

    // Natural SR period of 10 BS, then seeded scrambling after an SR.
    for (int i = 1; i <= 20; i++)
      cyc(BS9, FL9, ((i == 1) || (i == 11)) ? SR9 : BS9, FL9, 1'b0, 1'b0, 4, -1, "bs_period");
    cyc(BS9, D00, SR9, DFF, 1'b0, 1'b0, 4, -1, "sr21_seed");
    cyc(D00, D00, D17, DC0, 1'b0, 1'b0, 4, -1, "scrm_seq");
    cyc(BS9, FL9, BS9, FL9, 1'b0, 1'b0, 4, -1, "bs22");

    // Forced SR with counter at 5; afterwards the counter restarts from 1.
    for (int i = 0; i < 3; i++)
      cyc(BS9, FL9, BS9, FL9, 1'b0, 1'b0, 4, -1, "bs_to5");
    cyc(FL9, FL9, FL9, FL9, 1'b0, 1'b1, 4, -1, "req_idle");
    cyc(BS9, D00, SR9, DFF, 1'b1, 1'b0, 4, -1, "forced_sr");
    cyc(D00, D00, D17, DC0, 1'b0, 1'b0, 4, -1, "forced_scrm");
    for (int i = 0; i < 9; i++)
      cyc(BS9, FL9, BS9, FL9, 1'b0, 1'b0, 4, -1, "cnt_from1");
    cyc(BS9, FL9, SR9, FL9, 1'b0, 1'b0, 4, -1, "natural_sr");

    // Two requests while pending merge into one service.
    cyc(FL9, FL9, FL9, FL9, 1'b0, 1'b1, 4, -1, "req_a");
    cyc(FL9, FL9, FL9, FL9, 1'b0, 1'b1, 4, -1, "req_b");
    cyc(BS9, FL9, SR9, FL9, 1'b1, 1'b0, 4, -1, "merged_sr");
    cyc(BS9, FL9, BS9, FL9, 1'b0, 1'b0, 4, -1, "merged_once");

    // Request coinciding with service re-arms the flag.
    cyc(FL9, FL9, FL9, FL9, 1'b0, 1'b1, 4, -1, "req_c");
    cyc(BS9, FL9, SR9, FL9, 1'b1, 1'b1, 4, -1, "req_on_service");
    cyc(BS9, FL9, SR9, FL9, 1'b1, 1'b0, 4, -1, "set_dominates");
    cyc(BS9, FL9, BS9, FL9, 1'b0, 1'b0, 4, -1, "after_dom");

    // Two active lanes; the change lands one cycle after the input moves.
    c_lanes = 2'd1;
    cyc(FL9, FL9, FL9, FL9, 1'b0, 1'b1, 4, -1, "lanes_lag");
    cyc(BS9, D00, SR9, DFF, 1'b1, 1'b0, 2, -1, "two_lane_sr");
    cyc(D00, D00, D17, DC0, 1'b0, 1'b0, 2, -1, "two_lane_scrm");
    c_lanes = 2'd2;
    cyc(FL9, FL9, FL9, FL9, 1'b0, 1'b0, 2, -1, "lanes_back_lag");
    cyc(FL9, FL9, FL9, FL9, 1'b0, 1'b0, 4, -1, "lanes_back");

    // Enhanced framing: BS counted on the last sublane only; reseed lands on next cycle's slot 0.
    c_efm = 1'b1;
    cyc(FL9, FL9, FL9, FL9, 1'b0, 1'b1, 4, -1, "efm_req");
    cyc(BS9, FL9, BS9, FL9, 1'b0, 1'b0, 4, -1, "efm_s0_ignored");
    cyc(FL9, BS9, FL9, SR9, 1'b1, 1'b0, 4, -1, "efm_sr");
    cyc(D00, D00, DFF, D17, 1'b0, 1'b0, 4, -1, "efm_seed_next");
    c_efm = 1'b0;
    cyc(FL9, FL9, FL9, FL9, 1'b0, 1'b0, 4, -1, "efm_off");

    // Disabled: pass-through, no SR, request discarded, LFSR parked at seed.
    c_en = 1'b0;
    cyc(DA5, DA5, DA5, DA5, 1'b0, 1'b1, 4, -1, "dis_pass");
    cyc(BS9, FL9, BS9, FL9, 1'b0, 1'b0, 4, -1, "dis_bs_a");
    cyc(BS9, FL9, BS9, FL9, 1'b0, 1'b0, 4, -1, "dis_bs_b");
    c_en = 1'b1;
    cyc(D00, D00, DFF, D17, 1'b0, 1'b0, 4, -1, "en_seed");
    cyc(BS9, FL9, SR9, FL9, 1'b0, 1'b0, 4, -1, "en_first_sr");

    // Reset with a request pending: no ACK, first BS afterwards becomes SR.
    cyc(FL9, FL9, FL9, FL9, 1'b0, 1'b1, 4, 11, "req_before_rst");
    c_rst = 1'b1;
    cyc(FL9, FL9, Z9, Z9, 1'b0, 1'b0, 0, 0, "rst_mid");
    c_rst = 1'b0;
    cyc(BS9, FL9, SR9, FL9, 1'b0, 1'b0, 4, 1, "post_rst_sr");
    cyc(BS9, FL9, BS9, FL9, 1'b0, 1'b0, 4, 1, "post_rst_bs");

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

endmodule
